ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_if.sv | 21 ++
 rtl/ex_muldiv.sv | 90 +++++++++
 tb/tb_ex_muldiv.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage handshake between the pipeline (master) and the mul/div unit (slave).
interface ex_muldiv_if #(
   parameter int DATA_WIDTH          = 32,
   parameter int REGISTER_ADDR_WIDTH = 5
);
   logic                           start;
   logic [2:0]                     op;
   logic [DATA_WIDTH-1:0]          rs1_val;
   logic [DATA_WIDTH-1:0]          rs2_val;
   logic [REGISTER_ADDR_WIDTH-1:0] rd_in;
   logic                           flush;
   logic                           stall_req;
   logic                           busy;
   logic                           done;
   logic [DATA_WIDTH-1:0]          result;
   logic [REGISTER_ADDR_WIDTH-1:0] rd_out;
   modport master (output start, op, rs1_val, rs2_val, rd_in, flush,
                   input  stall_req, busy, done, result, rd_out);
   modport slave  (input  start, op, rs1_val, rs2_val, rd_in, flush,
                   output stall_req, busy, done, result, rd_out);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit, one bit per cycle on operand magnitudes,
// sign fix-up in a dedicated cycle, fast path for divide-by-zero and signed overflow.
module ex_muldiv #(
   parameter int DATA_WIDTH          = 32,
   parameter int REGISTER_ADDR_WIDTH = 5
) (
   input logic        clk,
   input logic        rst_n,
   ex_muldiv_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH) > 5 ? $clog2(DATA_WIDTH) : 5;
   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t                         state, state_n;
   logic [CW-1:0]                  cnt;
   logic [2:0]                     op_q;
   logic [REGISTER_ADDR_WIDTH-1:0] rd_q;
   logic                           neg_a, neg_b;
   logic [W-1:0]                   m;
   logic [2*W-1:0]                 acc, acc_step, prod_f;
   logic                           accept, sa, sb, a_neg, b_neg, dz, ovf;
   logic [W-1:0]                   a_mag, b_mag, fast_val, q_f, r_f, fix_val;
   logic [W:0]                     mul_sum, div_t, div_diff;
   assign accept = bus.start & (state == IDLE) & ~bus.flush;
   assign sa     = ~(bus.op[0] & (bus.op[1] | bus.op[2]));
   assign sb     = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
   assign a_neg  = sa & bus.rs1_val[W-1];
   assign b_neg  = sb & bus.rs2_val[W-1];
   assign a_mag  = a_neg ? -bus.rs1_val : bus.rs1_val;
   assign b_mag  = b_neg ? -bus.rs2_val : bus.rs2_val;
   assign dz     = bus.op[2] & (bus.rs2_val == '0);
   assign ovf    = bus.op[2] & ~bus.op[0] & (bus.rs1_val == MIN) & (bus.rs2_val == '1);
   assign fast_val = dz ? (bus.op[1] ? bus.rs1_val : '1) : (bus.op[1] ? '0 : MIN);
   // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
   assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? m : '0};
   assign div_t    = {acc[2*W-1:W], acc[W-1]};
   assign div_diff = div_t - {1'b0, m};
   assign acc_step = op_q[2] ? (div_diff[W] ? {div_t[W-1:0], acc[W-2:0], 1'b0}
                                            : {div_diff[W-1:0], acc[W-2:0], 1'b1})
                             : {mul_sum, acc[W-1:1]};
   assign prod_f  = (neg_a ^ neg_b) ? -acc : acc;
   assign q_f     = (neg_a ^ neg_b) ? -acc[W-1:0] : acc[W-1:0];
   assign r_f     = neg_a ? -acc[2*W-1:W] : acc[2*W-1:W];
   assign fix_val = op_q[2] ? (op_q[1] ? r_f : q_f)
                            : (op_q == 3'd0 ? prod_f[W-1:0] : prod_f[2*W-1:W]);
   assign bus.stall_req = accept | (state == CALC) | (state == FIX);
   assign bus.busy      = (state == CALC) | (state == FIX);
   assign bus.done      = state == DONE;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? (dz | ovf ? DONE : CALC) : IDLE;
         CALC:    state_n = bus.flush ? IDLE : (cnt == CW'(W-1) ? FIX : CALC);
         FIX:     state_n = bus.flush ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         op_q       <= '0;
         rd_q       <= '0;
         neg_a      <= 1'b0;
         neg_b      <= 1'b0;
         m          <= '0;
         acc        <= '0;
         bus.result <= '0;
         bus.rd_out <= '0;
      end else begin
         state <= state_n;
         cnt   <= state == CALC ? cnt + 1'b1 : '0;
         if (accept) begin
            op_q  <= bus.op;
            rd_q  <= bus.rd_in;
            neg_a <= a_neg;
            neg_b <= b_neg;
            m     <= bus.op[2] ? b_mag : a_mag;
            acc   <= {{W{1'b0}}, bus.op[2] ? a_mag : b_mag};
         end else if (state == CALC) begin
            acc <= acc_step;
         end
         if (state_n == DONE) begin
            bus.result <= state == IDLE ? fast_val : fix_val;
            bus.rd_out <= state == IDLE ? bus.rd_in : rd_q;
         end
      end
   end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed RV32M vectors with hand-computed results, latency, flush and reset checks.
module tb_ex_muldiv;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   ex_muldiv_if #(.DATA_WIDTH(32), .REGISTER_ADDR_WIDTH(5)) bus ();
   ex_muldiv #(.DATA_WIDTH(32), .REGISTER_ADDR_WIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   // called at a negedge; cycle 0 is the accept cycle
   task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
      int   n;
      logic st_ok;
      bus.op = o; bus.rs1_val = a; bus.rs2_val = b; bus.rd_in = rd; bus.start = 1'b1;
      #1;
      chk({tag, " stall0"}, bus.stall_req, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      st_ok = 1'b1;
      while (!bus.done && n < 60) begin
         if (!bus.stall_req || !bus.busy) st_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, n, lat);
      chk({tag, " stall/busy"}, st_ok, 1'b1);
      chk({tag, " stall in done"}, {bus.stall_req, bus.busy}, 2'b00);
      chk({tag, " result"}, bus.result, exp);
      chk({tag, " rd_out"}, bus.rd_out, rd);
      @(negedge clk);
      chk({tag, " done pulse"}, bus.done, 1'b0);
      chk({tag, " hold"}, bus.result, exp);
   endtask
   initial begin
      logic seen;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
      bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0;
      #12;
      chk("reset outs", {bus.done, bus.busy, bus.stall_req}, 3'b000);
      chk("reset result", bus.result, 32'h0);
      chk("reset rd_out", bus.rd_out, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("MUL 7*-3",      3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34);
      do_op("MUL -3*-5",     3'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, 5'd1,  32'h0000000F, 34);
      do_op("MUL -1*-1",     3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000001, 34);
      do_op("MULH min*min",  3'd1, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, 34);
      do_op("MULH -1*1",     3'd1, 32'hFFFFFFFF, 32'h00000001, 5'd4,  32'hFFFFFFFF, 34);
      do_op("MULHSU",        3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 34);
      do_op("MULHU max",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34);
      do_op("MULHU x10",     3'd3, 32'h12345678, 32'h00000010, 5'd8,  32'h00000001, 34);
      do_op("DIV -7/2",      3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34);
      do_op("REM -7/2",      3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34);
      do_op("DIVU",          3'd5, 32'hFFFFFFF9, 32'd2,        5'd11, 32'h7FFFFFFC, 34);
      do_op("REMU",          3'd7, 32'hFFFFFFF9, 32'd2,        5'd12, 32'h00000001, 34);
      do_op("DIV 100/-7",    3'd4, 32'd100,      32'hFFFFFFF9, 5'd13, 32'hFFFFFFF2, 34);
      do_op("REM -100/7",    3'd6, 32'hFFFFFF9C, 32'd7,        5'd14, 32'hFFFFFFFE, 34);
      do_op("DIVU 5/0",      3'd5, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1);
      do_op("REMU 5/0",      3'd7, 32'd5,        32'd0,        5'd16, 32'h00000005, 1);
      do_op("DIV -5/0",      3'd4, 32'hFFFFFFFB, 32'd0,        5'd17, 32'hFFFFFFFF, 1);
      do_op("REM -5/0",      3'd6, 32'hFFFFFFFB, 32'd0,        5'd18, 32'hFFFFFFFB, 1);
      do_op("DIV ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1);
      do_op("REM ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000, 1);
      // flush 10 cycles into a multiply
      bus.op = 3'd0; bus.rs1_val = 32'd3; bus.rs2_val = 32'd4; bus.rd_in = 5'd21; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("flush busy before", bus.busy, 1'b1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush busy after", {bus.busy, bus.done}, 2'b00);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      chk("flush no done", seen, 1'b0);
      chk("flush result kept", bus.result, 32'h00000000);
      do_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd22, 32'h0000000E, 34);
      // start together with flush is not accepted
      bus.op = 3'd0; bus.start = 1'b1; bus.flush = 1'b1;
      #1;
      chk("start+flush stall", bus.stall_req, 1'b0);
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("start+flush idle", {bus.busy, bus.done}, 2'b00);
      // flush in DONE keeps the pulse
      bus.op = 3'd5; bus.rs1_val = 32'd9; bus.rs2_val = 32'd0; bus.rd_in = 5'd23; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b1;
      #1;
      chk("flush in done", bus.done, 1'b1);
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush in done result", bus.result, 32'hFFFFFFFF);
      // reset 15 cycles into a divide
      bus.op = 3'd4; bus.rs1_val = 32'hFFFFFFF9; bus.rs2_val = 32'd2; bus.rd_in = 5'd9; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      chk("pre reset busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async reset outs", {bus.done, bus.busy, bus.stall_req}, 3'b000);
      chk("async reset result", bus.result, 32'h0);
      chk("async reset rd_out", bus.rd_out, 5'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen = 1'b1;
      end
      chk("reset no done", seen, 1'b0);
      do_op("REM after reset", 3'd6, 32'd100, 32'd7, 5'd30, 32'h00000002, 34);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
